// File: rtl/mips_bus_arbiter.sv
// ============================================================================
// Module   : mips_bus_arbiter
// Summary  : Round-robin Avalon-MM master shared by NUM_CH requesters, with
//            lane steering, misalignment check and waitrequest timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_bus_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH-1:0]        ch_signed,
    input  logic [2*NUM_CH-1:0]      ch_size,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
    output logic [DATA_W*NUM_CH-1:0] ch_rdata,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [ADDR_W-1:0]        address,
    output logic                     read,
    output logic                     write,
    input  logic                     waitrequest,
    output logic [DATA_W-1:0]        writedata,
    output logic [DATA_W/8-1:0]      byteenable,
    input  logic [DATA_W-1:0]        readdata
);

    localparam int NB        = DATA_W / 8;
    localparam int OFF_W     = $clog2(NB);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] C_TO_LAST = TO_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_gnt;
    logic [CH_W-1:0]     w_gnt;
    logic [CH_W-1:0]     w_rr_next;
    logic                w_any;
    logic                r_we;
    logic                r_signed;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                w_sel_we;
    logic                w_sel_signed;
    logic [1:0]          w_sel_size;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_bad;
    logic                w_timeout;
    logic                w_in_bus;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wrep;
    logic [DATA_W-1:0]   w_rd_ext;

    // First requester found scanning upward from the round-robin pointer
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_CH;
            if (!w_any && ch_req[idx]) begin
                w_any = 1'b1;
                w_gnt = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        int gi;
        gi           = int'(w_gnt);
        w_sel_we     = ch_we[gi];
        w_sel_signed = ch_signed[gi];
        w_sel_size   = ch_size[2*gi +: 2];
        w_sel_addr   = ch_addr[ADDR_W*gi +: ADDR_W];
        w_sel_wdata  = ch_wdata[DATA_W*gi +: DATA_W];
        case (w_sel_size)
            2'd0:    w_bad = 1'b0;
            2'd1:    w_bad = w_sel_addr[0];
            2'd2:    w_bad = |w_sel_addr[1:0];
            default: w_bad = (DATA_W == 32) || (|w_sel_addr[2:0]);
        endcase
    end

    assign w_in_bus  = (r_state == S_BUS);
    assign w_timeout = (TIMEOUT != 0) && w_in_bus && waitrequest && (r_wait_cnt == C_TO_LAST);
    assign w_rr_next = (int'(r_gnt) == NUM_CH - 1) ? '0 : r_gnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_next = w_bad ? S_RESP : S_BUS;
            S_BUS:  if (!waitrequest || w_timeout) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane steering from the latched request fields
    always_comb begin
        int nbytes;
        int off;
        logic sign;
        nbytes   = 1 << int'(r_size);
        off      = int'(r_addr[OFF_W-1:0]);
        sign     = 1'b0;
        w_be     = '0;
        w_wrep   = '0;
        w_rd_ext = '0;
        for (int b = 0; b < NB; b++) begin
            w_be[b]          = (b >= off) && (b < off + nbytes);
            w_wrep[8*b +: 8] = r_wdata[8*(b % nbytes) +: 8];
            if (b < nbytes) begin
                w_rd_ext[8*b +: 8] = readdata[8*((off + b) & (NB - 1)) +: 8];
                if (b == nbytes - 1) sign = readdata[8*((off + b) & (NB - 1)) + 7];
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (b >= nbytes) w_rd_ext[8*b +: 8] = {8{sign & r_signed}};
        end
    end

    assign read       = w_in_bus && !r_we;
    assign write      = w_in_bus && r_we;
    assign address    = w_in_bus ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign byteenable = w_in_bus ? w_be : '0;
    assign writedata  = w_in_bus ? w_wrep : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            ch_rdata   <= '0;
            ch_done    <= '0;
            ch_err     <= '0;
        end else begin
            ch_done <= '0;
            ch_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_gnt;
                        r_we       <= w_sel_we;
                        r_signed   <= w_sel_signed;
                        r_size     <= w_sel_size;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_err      <= w_bad;
                        r_wait_cnt <= '0;
                    end
                end
                S_BUS: begin
                    if (!waitrequest) begin
                        if (!r_we) ch_rdata[DATA_W*int'(r_gnt) +: DATA_W] <= w_rd_ext;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    ch_done[r_gnt] <= 1'b1;
                    ch_err[r_gnt]  <= r_err;
                    r_rr_ptr       <= w_rr_next;
                    r_wait_cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
// ============================================================================
// Module   : tb_mips_bus_arbiter
// Summary  : Directed vector bench for mips_bus_arbiter (2 ch, 32-bit, TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_req, ch_we, ch_signed;
    logic [3:0]  ch_size;
    logic [63:0] ch_addr, ch_wdata;
    logic [63:0] ch_rdata;
    logic [1:0]  ch_done, ch_err;
    logic [31:0] address;
    logic        read, write, waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_rdata [2];

    mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_signed(ch_signed),
        .ch_size(ch_size), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
        .ch_done(ch_done), .ch_err(ch_err), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic        we;
        logic        sgn;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(int ch, logic we, logic sgn, logic [1:0] size, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rd, int waits, logic [31:0] e_addr,
                                logic [3:0] e_be, logic [31:0] e_wd, logic [31:0] e_rdata, logic e_err);
        vec_t v;
        v.ch = ch; v.we = we; v.sgn = sgn; v.size = size; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.waits = waits; v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd;
        v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic we, input logic sgn, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        ch_we[ch]              = we;
        ch_signed[ch]          = sgn;
        ch_size[2*ch +: 2]     = size;
        ch_addr[32*ch +: 32]   = addr;
        ch_wdata[32*ch +: 32]  = wdata;
    endtask

    // Called just after a falling edge; returns just after the falling edge where done was seen.
    task automatic run_vec(input vec_t v, input int n);
        int lat, strobes, left, exp_lat, exp_str;
        bit done;
        string tag;
        tag = $sformatf("v%0d", n);
        set_ch(v.ch, v.we, v.sgn, v.size, v.addr, v.wdata);
        ch_req[v.ch] = 1'b1;
        left = v.waits; lat = 0; strobes = 0; done = 1'b0;
        exp_lat = v.e_err ? 2 : 3 + v.waits;
        exp_str = v.e_err ? 0 : v.waits + 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (read || write) begin
                strobes++;
                chk({tag, " address"}, address, v.e_addr);
                chk({tag, " byteenable"}, byteenable, v.e_be);
                chk({tag, " strobe dir"}, {read, write}, {~v.we, v.we});
                if (v.we) chk({tag, " writedata"}, writedata, v.e_wd);
                if (left > 0) begin
                    waitrequest = 1'b1;
                    left--;
                end else begin
                    waitrequest = 1'b0;
                    readdata    = v.rd;
                end
            end
            if (ch_done != 2'b00) begin
                done = 1'b1;
                chk({tag, " done"}, ch_done, 2'b01 << v.ch);
                chk({tag, " err"}, ch_err, {1'b0, v.e_err} << v.ch);
                chk({tag, " latency"}, lat, exp_lat);
                chk({tag, " strobe cycles"}, strobes, exp_str);
                ch_req[v.ch] = 1'b0;
                waitrequest  = 1'b0;
            end
        end
        if (!done) chk({tag, " done seen"}, 0, 1);
        if (!v.we && !v.e_err) m_rdata[v.ch] = v.e_rdata;
        chk({tag, " ch_rdata"}, ch_rdata[32*v.ch +: 32], m_rdata[v.ch]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] order [4];
        int n, reads;
        bit done;

        vt[0]  = mk(1, 0, 1, 2'd0, 32'h1001, 32'h0, 32'h12348055, 0, 32'h1000, 4'b0010, 32'h0, 32'hFFFFFF80, 0);
        vt[1]  = mk(1, 0, 0, 2'd0, 32'h1001, 32'h0, 32'h12348055, 0, 32'h1000, 4'b0010, 32'h0, 32'h00000080, 0);
        vt[2]  = mk(0, 0, 1, 2'd1, 32'h2002, 32'h0, 32'h80017FFF, 0, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 0);
        vt[3]  = mk(0, 0, 0, 2'd1, 32'h2000, 32'h0, 32'h80017FFF, 1, 32'h2000, 4'b0011, 32'h0, 32'h00007FFF, 0);
        vt[4]  = mk(1, 0, 1, 2'd2, 32'h3000, 32'h0, 32'hDEADBEEF, 2, 32'h3000, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
        vt[5]  = mk(1, 1, 0, 2'd0, 32'h4003, 32'h123456A5, 32'h0, 0, 32'h4000, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
        vt[6]  = mk(0, 1, 0, 2'd2, 32'h5004, 32'h01234567, 32'h0, 0, 32'h5004, 4'b1111, 32'h01234567, 32'h0, 0);
        vt[7]  = mk(1, 0, 0, 2'd2, 32'h3001, 32'h0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
        vt[8]  = mk(0, 1, 0, 2'd1, 32'h2001, 32'h0000BEEF, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
        vt[9]  = mk(1, 0, 0, 2'd3, 32'h6000, 32'h0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
        vt[10] = mk(0, 0, 1, 2'd0, 32'h1003, 32'h0, 32'h7F000000, 0, 32'h1000, 4'b1000, 32'h0, 32'h0000007F, 0);
        vt[11] = mk(0, 1, 0, 2'd1, 32'h2002, 32'h0000ABCD, 32'h0, 3, 32'h2000, 4'b1100, 32'hABCDABCD, 32'h0, 0);

        reset = 1'b0; ch_req = '0; ch_we = '0; ch_signed = '0; ch_size = '0;
        ch_addr = '0; ch_wdata = '0; waitrequest = 1'b0; readdata = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset strobes", {read, write}, 2'b00);
        chk("reset address", address, 32'h0);
        chk("reset byteenable", byteenable, 4'h0);
        chk("reset done/err", {ch_done, ch_err}, 4'h0);
        chk("reset rdata", ch_rdata, 64'h0);
        reset = 1'b1;

        // Asynchronous reset in the middle of a stalled read
        @(negedge clk);
        set_ch(0, 1'b0, 1'b0, 2'd2, 32'h0100, 32'h0);
        ch_req[0] = 1'b1; waitrequest = 1'b1;
        @(negedge clk);
        chk("pre-reset read", read, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async reset read", read, 1'b0);
        chk("async reset byteenable", byteenable, 4'h0);
        chk("async reset done", ch_done, 2'b00);
        @(negedge clk);
        reset = 1'b1; ch_req = '0; waitrequest = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post-reset quiet", {ch_done, read, write}, 4'h0);
        end

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // Round-robin with both channels requesting from reset
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        set_ch(0, 1'b0, 1'b0, 2'd2, 32'h8000, 32'h0);
        set_ch(1, 1'b0, 1'b0, 2'd2, 32'h8004, 32'h0);
        readdata = 32'h55AA1234; waitrequest = 1'b0;
        ch_req = 2'b11;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (ch_done != 2'b00) begin
                order[n] = ch_done;
                chk("rr err", ch_err, 2'b00);
                n++;
                if (n == 4) ch_req = 2'b00;
            end
        end
        chk("rr count", n, 4);
        for (int i = 0; i < n; i++) chk($sformatf("rr grant %0d", i), order[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        m_rdata[0] = 32'h55AA1234; m_rdata[1] = 32'h55AA1234;
        chk("rr rdata", ch_rdata, {m_rdata[1], m_rdata[0]});

        // Timeout: waitrequest never drops
        @(negedge clk);
        set_ch(0, 1'b0, 1'b1, 2'd2, 32'h7000, 32'h0);
        readdata = 32'hFFFF0000; waitrequest = 1'b1;
        ch_req[0] = 1'b1;
        reads = 0; done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (read) reads++;
            if (ch_done != 2'b00) begin
                done = 1'b1;
                chk("timeout done", ch_done, 2'b01);
                chk("timeout err", ch_err, 2'b01);
                ch_req = 2'b00;
            end
        end
        waitrequest = 1'b0;
        chk("timeout done seen", done, 1'b1);
        chk("timeout read cycles", reads, 4);
        chk("timeout rdata kept", ch_rdata[31:0], m_rdata[0]);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
